// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//
// Streaming read engine for a simple-dual-port block RAM whose read port has
// a 2-cycle registered latency. A (start address, length) command is taken
// over a valid/ready handshake. The engine then issues one RAM read per cycle
// while it has credit, catches the returning words in a small FIFO, and
// presents them in order on a valid/ready stream. The final word of each
// command is flagged with m_last.
//
// Ports:
//   clk, rst                      single clock, async active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_addr, cmd_len             first word address, word count (0 legal)
//   bram_addrb, bram_enb          RAM read address / read enable (registered)
//   bram_regceb, bram_rstb        RAM output-register enable / reset (rstb = 0)
//   bram_doutb                    RAM read data
//   m_valid/m_ready               output stream handshake
//   m_data, m_last                output word and end-of-command flag
//   done                          one-cycle pulse when a command completes
module bram_stream_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = 10,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    output logic                  bram_enb,
    output logic                  bram_regceb,
    output logic                  bram_rstb,
    input  logic [DATA_WIDTH-1:0] bram_doutb,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 2;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  issue_last;
    logic                  done_zero;
    logic [RD_LATENCY-1:0] rd_vld;
    logic [RD_LATENCY-1:0] rd_last;

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_tag;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;

    logic                  push;
    logic                  pop;
    logic                  cmd_fire;
    logic                  burst_done;
    logic [OCC_W-1:0]      inflight_cnt;
    logic [OCC_W-1:0]      occupancy;
    logic                  credit_ok;

    assign bram_rstb   = 1'b0;
    assign bram_regceb = rd_vld[0];

    // The final latency stage lines up with valid doutb, so it is the push.
    assign push       = rd_vld[RD_LATENCY-1];
    assign m_valid    = (fifo_count != '0);
    assign pop        = m_valid & m_ready;
    assign m_data     = m_valid ? fifo_data[rd_ptr] : '0;
    assign m_last     = m_valid & fifo_tag[rd_ptr];

    // A zero-length command holds off the next accept until its done pulse
    // has gone by, matching the one-command-per-done rhythm of real bursts.
    assign cmd_ready  = (state == IDLE) & ~done_zero & ~rst;
    assign cmd_fire   = cmd_valid & cmd_ready;
    assign burst_done = (state == DRAIN) & pop & m_last;
    assign done       = done_zero | burst_done;

    // Credit check for the read registered this cycle (visible next cycle).
    // Everything already committed -- FIFO contents, the read on the port now
    // and the reads in the latency pipe -- must leave room for one more word.
    // A pop this cycle frees its slot in time, which keeps a full-rate stream.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + OCC_W'(rd_vld[i]);
        end
        occupancy = OCC_W'(fifo_count) + OCC_W'(bram_enb) + inflight_cnt
                    - OCC_W'(pop);
        credit_ok = (occupancy < OCC_W'(FIFO_DEPTH));
    end

    // Control FSM. The first read is registered on the accept edge itself so
    // the RAM sees it one cycle after the command handshake. Reads carry a
    // last tag down a shift register matched to the RAM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            next_addr  <= '0;
            remaining  <= '0;
            bram_addrb <= '0;
            bram_enb   <= 1'b0;
            issue_last <= 1'b0;
            done_zero  <= 1'b0;
            rd_vld     <= '0;
            rd_last    <= '0;
        end else begin
            bram_enb   <= 1'b0;
            issue_last <= 1'b0;
            done_zero  <= 1'b0;
            rd_vld     <= {rd_vld[RD_LATENCY-2:0], bram_enb};
            rd_last    <= {rd_last[RD_LATENCY-2:0], issue_last};
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        if (cmd_len == '0) begin
                            done_zero <= 1'b1;
                        end else begin
                            bram_enb   <= 1'b1;
                            bram_addrb <= cmd_addr;
                            next_addr  <= cmd_addr + ADDR_WIDTH'(1);
                            remaining  <= cmd_len - LEN_WIDTH'(1);
                            issue_last <= (cmd_len == LEN_WIDTH'(1));
                            state      <= (cmd_len == LEN_WIDTH'(1)) ? DRAIN : ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if ((remaining != '0) && credit_ok) begin
                        bram_enb   <= 1'b1;
                        bram_addrb <= next_addr;
                        next_addr  <= next_addr + ADDR_WIDTH'(1);
                        remaining  <= remaining - LEN_WIDTH'(1);
                        issue_last <= (remaining == LEN_WIDTH'(1));
                        if (remaining == LEN_WIDTH'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (burst_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO bookkeeping. Pointers wrap naturally because the depth is a power
    // of two; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_tag   <= '0;
        end else begin
            if (push) begin
                wr_ptr           <= wr_ptr + PTR_W'(1);
                fifo_tag[wr_ptr] <= rd_last[RD_LATENCY-1];
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage needs no reset; empty entries are masked at the output.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bram_doutb;
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader
//
// Bench for bram_stream_reader. A behavioural 2-cycle RAM preloaded with
// word[i] = i feeds the DUT. Commands push their expected words and read
// addresses into queues; a monitor on the falling edge pops and compares
// whenever the DUT presents a handshake or issues a read.
module tb_bram_stream_reader;

    localparam int DW = 64;
    localparam int AW = 9;
    localparam int LW = 10;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [AW-1:0] bram_addrb;
    logic          bram_enb;
    logic          bram_regceb;
    logic          bram_rstb;
    logic [DW-1:0] bram_doutb;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_done = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int hs_total = 0;
    int ready_mode = 0;
    logic [3:0] ready_pat = 4'b1001;

    logic [DW:0]   exp_q [$];
    logic [AW-1:0] addr_q [$];

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;

    bram_stream_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
        .RD_LATENCY(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .bram_addrb(bram_addrb), .bram_enb(bram_enb),
        .bram_regceb(bram_regceb), .bram_rstb(bram_rstb),
        .bram_doutb(bram_doutb),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
        ram_q      = '0;
        bram_doutb = '0;
    end

    // RAM model: array read on the enable cycle, output register one later.
    always @(posedge clk) begin
        if (bram_enb) ram_q <= ram[bram_addrb];
        if (bram_rstb) bram_doutb <= '0;
        else if (bram_regceb) bram_doutb <= ram_q;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Consumer: always ready, or the repeating 1,0,0,1 pattern.
    initial begin
        int k;
        k = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (ready_mode != 0) ? ready_pat[k % 4] : 1'b1;
            k++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic failNote(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor: read addresses, credit, data hold under stall, output words.
    initial begin
        int iss, popc;
        logic prev_stall, prev_last, hs;
        logic [DW-1:0] prev_data;
        logic [DW:0] e;
        iss = 0; popc = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                iss = 0; popc = 0; prev_stall = 0;
            end else begin
                hs = m_valid & m_ready;
                if (bram_enb) begin
                    checkOutput("enb_credit", 64'((iss - popc) < 4), 64'd1);
                    if (addr_q.size() == 0) failNote("unexpected_read");
                    else checkOutput("rd_addr", 64'(bram_addrb), 64'(addr_q.pop_front()));
                end
                if (prev_stall) begin
                    checkOutput("hold_valid", 64'(m_valid), 64'd1);
                    checkOutput("hold_data", m_data, prev_data);
                    checkOutput("hold_last", 64'(m_last), 64'(prev_last));
                end
                if (hs) begin
                    hs_total++;
                    if (exp_q.size() == 0) failNote("unexpected_word");
                    else begin
                        e = exp_q.pop_front();
                        checkOutput("m_data", m_data, e[DW-1:0]);
                        checkOutput("m_last", 64'(m_last), 64'(e[DW]));
                        checkOutput("done_with_last", 64'(done), 64'(m_last));
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_stall = m_valid & ~m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
                iss  += int'(bram_enb);
                popc += int'(hs);
            end
        end
    end

    // Queue the expected reads/words, then hold cmd_valid until accepted.
    // Returns in the cycle after acceptance with the accept cycle number.
    task automatic applyStimulus(input logic [AW-1:0] a, input logic [LW-1:0] len,
                                 output int t_acc);
        logic acc;
        logic [AW-1:0] ai;
        for (int i = 0; i < int'(len); i++) begin
            ai = a + AW'(i);
            addr_q.push_back(ai);
            exp_q.push_back({(i == int'(len) - 1), DW'(ai)});
        end
        exp_done++;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_valid = 1'b1;
        acc   = 1'b0;
        t_acc = -1;
        for (int k = 0; k < 500 && !acc; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc   = 1'b1;
                t_acc = cyc;
            end
        end
        if (!acc) failNote("cmd_accept_timeout");
        else begin
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int k;
        for (k = 0; k < 300; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (k >= 300) failNote({name, "_drain_timeout"});
        repeat (8) @(posedge clk);
        #1;
        checkOutput({name, "_addr_left"}, 64'(addr_q.size()), 64'd0);
        checkOutput({name, "_done_count"}, 64'(done_cnt), 64'(exp_done));
    endtask

    initial begin
        int t, t2, base;
        logic ok;
        rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        checkOutput("rst_enb", 64'(bram_enb), 64'd0);
        checkOutput("rst_addrb", 64'(bram_addrb), 64'd0);
        checkOutput("rst_regceb", 64'(bram_regceb), 64'd0);
        checkOutput("rst_rstb", 64'(bram_rstb), 64'd0);
        checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
        checkOutput("rst_m_data", m_data, 64'd0);
        checkOutput("rst_m_last", 64'(m_last), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 checkOutput("rel_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;

        // Full-rate burst: enb T+1..T+4, m_valid T+4..T+7, last/done T+7.
        $display("[TB] test: full rate addr 0x10 len 4");
        applyStimulus(9'h010, 10'd4, t);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checkOutput($sformatf("fr_enb_T%0d", k), 64'(bram_enb), 64'(k <= 4));
            checkOutput($sformatf("fr_valid_T%0d", k), 64'(m_valid), 64'(k >= 4 && k <= 7));
            checkOutput($sformatf("fr_last_T%0d", k), 64'(m_last), 64'(k == 7));
            checkOutput($sformatf("fr_done_T%0d", k), 64'(done), 64'(k == 7));
        end
        waitDrain("fullrate");

        $display("[TB] test: backpressure 1,0,0,1");
        ready_mode = 1;
        applyStimulus(9'h010, 10'd4, t);
        waitDrain("backpressure");
        ready_mode = 0;
        @(posedge clk); #1;

        $display("[TB] test: address wrap 510 len 4");
        applyStimulus(9'd510, 10'd4, t);
        waitDrain("wrap");

        $display("[TB] test: zero length");
        applyStimulus(9'h055, 10'd0, t);
        @(negedge clk);
        checkOutput("z_done_T1", 64'(done), 64'd1);
        checkOutput("z_ready_T1", 64'(cmd_ready), 64'd0);
        checkOutput("z_enb_T1", 64'(bram_enb), 64'd0);
        @(negedge clk);
        checkOutput("z_done_T2", 64'(done), 64'd0);
        checkOutput("z_ready_T2", 64'(cmd_ready), 64'd1);
        checkOutput("z_valid_T2", 64'(m_valid), 64'd0);
        waitDrain("zero");

        $display("[TB] test: reset mid-burst");
        base = hs_total;
        applyStimulus(9'h000, 10'd8, t);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(posedge clk);
            if (hs_total >= base + 2) ok = 1'b1;
        end
        if (!ok) failNote("mid_reset_wait_timeout");
        #1 rst = 1'b1;
        exp_done--;
        exp_q.delete();
        addr_q.delete();
        #1;
        checkOutput("mr_cmd_ready", 64'(cmd_ready), 64'd0);
        checkOutput("mr_enb", 64'(bram_enb), 64'd0);
        checkOutput("mr_addrb", 64'(bram_addrb), 64'd0);
        checkOutput("mr_regceb", 64'(bram_regceb), 64'd0);
        checkOutput("mr_m_valid", 64'(m_valid), 64'd0);
        checkOutput("mr_m_data", m_data, 64'd0);
        checkOutput("mr_m_last", 64'(m_last), 64'd0);
        checkOutput("mr_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 checkOutput("mr_rel_ready", 64'(cmd_ready), 64'd1);
        applyStimulus(9'h020, 10'd2, t);
        waitDrain("after_reset");

        // First done at T1+6, second command accepted at T1+7.
        $display("[TB] test: back-to-back commands");
        applyStimulus(9'h000, 10'd3, t);
        applyStimulus(9'h040, 10'd2, t2);
        checkOutput("b2b_first_done", 64'(done_cyc), 64'(t + 6));
        checkOutput("b2b_accept", 64'(t2), 64'(t + 7));
        waitDrain("b2b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
